// File: rtl/aemb_dwb_stu.sv
// Data-bus load/store master: one Wishbone classic cycle per X-stage memory op.
// Optional bus-timeout abort is enabled by defining AEMB_DWB_TIMEOUT_EN.
module aemb_dwb_stu #(
  parameter int AW  = 32,
  parameter int TOW = 8
) (
  input  logic          gclk,
  input  logic          grst,
  input  logic          x_stb,
  input  logic          x_wre,
  input  logic [1:0]    x_siz,
  input  logic [AW-1:0] x_adr,
  input  logic [31:0]   x_dd,
  output logic          x_stall,
  output logic [3:0]    m_sel,
  output logic [31:0]   m_dwb,
  output logic          m_ack,
  output logic          m_err,
  output logic [AW-3:0] dwb_adr_o,
  output logic [31:0]   dwb_dat_o,
  output logic [3:0]    dwb_sel_o,
  output logic          dwb_stb_o,
  output logic          dwb_cyc_o,
  output logic          dwb_wre_o,
  input  logic [31:0]   dwb_dat_i,
  input  logic          dwb_ack_i
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_BUSY = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  logic [1:0] state_r;
  logic       timeout_s;

  // Big-endian lane enables: byte 0 lives in [31:24].
  function automatic logic [3:0] lane_sel(input logic [1:0] siz, input logic [1:0] adr);
    logic [3:0] sel;
    case (siz)
      2'b00: begin
        case (adr)
          2'b00:   sel = 4'b1000;
          2'b01:   sel = 4'b0100;
          2'b10:   sel = 4'b0010;
          default: sel = 4'b0001;
        endcase
      end
      2'b01:   sel = adr[1] ? 4'b0011 : 4'b1100;
      default: sel = 4'b1111;
    endcase
    return sel;
  endfunction

  function automatic logic [31:0] store_dat(input logic [1:0] siz, input logic [31:0] dd);
    logic [31:0] dat;
    case (siz)
      2'b00:   dat = {4{dd[7:0]}};
      2'b01:   dat = {2{dd[15:0]}};
      default: dat = dd;
    endcase
    return dat;
  endfunction

  // Pipeline hold: the requesting cycle plus every bus-wait cycle; released in DONE.
  always_comb begin
    x_stall = 1'b0;
    if (state_r == ST_BUSY) begin
      x_stall = 1'b1;
    end else if (state_r == ST_IDLE) begin
      x_stall = x_stb;
    end else begin
      x_stall = 1'b0;
    end
  end

`ifdef AEMB_DWB_TIMEOUT_EN
  logic [TOW-1:0] tmo_cnt_r;
  logic           m_err_r;

  // Abort when this BUSY cycle would bring the wait count to all-ones; ack wins.
  always_comb begin
    timeout_s = 1'b0;
    if (state_r == ST_BUSY && !dwb_ack_i) begin
      timeout_s = (tmo_cnt_r == {{(TOW-1){1'b1}}, 1'b0});
    end else begin
      timeout_s = 1'b0;
    end
  end

  // Wait-cycle counter, cleared while idle so it starts at zero in BUSY.
  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      tmo_cnt_r <= {TOW{1'b0}};
      m_err_r   <= 1'b0;
    end else begin
      m_err_r <= timeout_s;
      if (state_r == ST_IDLE) begin
        tmo_cnt_r <= {TOW{1'b0}};
      end else if (state_r == ST_BUSY && !dwb_ack_i) begin
        tmo_cnt_r <= tmo_cnt_r + {{(TOW-1){1'b0}}, 1'b1};
      end else begin
        tmo_cnt_r <= tmo_cnt_r;
      end
    end
  end

  assign m_err = m_err_r;
`else
  logic [TOW-1:0] unused_tow_s;
  assign unused_tow_s = {TOW{1'b0}};
  assign timeout_s    = 1'b0;
  assign m_err        = 1'b0;
`endif

  // Bus-cycle FSM; all bus and completion outputs are registered here.
  always_ff @(posedge gclk or negedge grst) begin
    if (!grst) begin
      state_r   <= ST_IDLE;
      dwb_adr_o <= {(AW-2){1'b0}};
      dwb_dat_o <= 32'h0000_0000;
      dwb_sel_o <= 4'b0000;
      dwb_stb_o <= 1'b0;
      dwb_cyc_o <= 1'b0;
      dwb_wre_o <= 1'b0;
      m_sel     <= 4'b0000;
      m_dwb     <= 32'h0000_0000;
      m_ack     <= 1'b0;
    end else begin
      m_ack <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (x_stb) begin
            dwb_adr_o <= x_adr[AW-1:2];
            dwb_dat_o <= store_dat(x_siz, x_dd);
            dwb_sel_o <= lane_sel(x_siz, x_adr[1:0]);
            dwb_wre_o <= x_wre;
            dwb_stb_o <= 1'b1;
            dwb_cyc_o <= 1'b1;
            state_r   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (dwb_ack_i || timeout_s) begin
            dwb_stb_o <= 1'b0;
            dwb_cyc_o <= 1'b0;
            m_sel     <= dwb_sel_o;
            m_ack     <= 1'b1;
            state_r   <= ST_DONE;
            if (!dwb_ack_i) begin
              m_dwb <= 32'h0000_0000;
            end else if (!dwb_wre_o) begin
              m_dwb <= dwb_dat_i;
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          dwb_stb_o <= 1'b0;
          dwb_cyc_o <= 1'b0;
          state_r   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
